axil_regbank_param: RTL
=======================

Name: axil_regbank_param

Overview:
Parametrised AXI4-Lite slave register bank, the next-generation replacement for the fixed 12-register AXI-Lite example block. Register count, address/data width, base address, per-register type and reset value are all generic. Adds correct address decode, SLVERR/DECERR responses, hardware-side status/set inputs and per-register write-lock. Sits between the AXI-Lite interconnect and a peripheral core.

Parameters:
ADDR_W, 12, AXI address width.
DATA_W, 32, data width; 32 or 64 only.
NUM_REGS, 16, number of registers, 1..256.
BASE_ADDR, 0, byte address of register 0; must be aligned to NUM_REGS*DATA_W/8.
REG_TYPE, all RW, packed NUM_REGS*3 bits; per register: 0 RW, 1 RO, 2 WO, 3 W1C, 4 W1P (pulse), 5 RC (read-clear).
RESET_VAL, all zero, packed NUM_REGS*DATA_W reset values.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axil_aw{addr,valid,ready}  in/in/out  ADDR_W/1/1  write address channel
s_axil_w{data,strb,valid,ready}  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
s_axil_b{resp,valid,ready}  out/out/in  2/1/1  write response channel
s_axil_ar{addr,valid,ready}  in/in/out  ADDR_W/1/1  read address channel
s_axil_r{data,resp,valid,ready}  out/out/out/in  DATA_W/2/1/1  read data channel
hw_rdata  in  NUM_REGS*DATA_W  live value returned for RO registers
hw_set  in  NUM_REGS*DATA_W  per-bit set for W1C and RC registers
lock  in  NUM_REGS  1 blocks bus writes to that register
reg_q  out  NUM_REGS*DATA_W  current register contents (RW, WO, W1C, RC)
pulse_q  out  NUM_REGS*DATA_W  one-cycle pulses for W1P registers

Behaviour:
- Reset: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=OKAY; rdata=0; reg_q=RESET_VAL; pulse_q=0. Reset asserted mid-transaction abandons it with no response.
- Decode: idx=(addr-BASE_ADDR)>>log2(DATA_W/8). DECERR if addr is below base, idx>=NUM_REGS, or addr is misaligned. Decode is never left to a case on equal constants.
- Write: AW and W are accepted independently; each ready drops after its handshake. Commit happens in the first cycle both are held and bvalid=0. Registers update on that edge; bvalid rises on the same edge. awready/wready return to 1 on the cycle after the B handshake. AW and W in the same cycle T give bvalid at T+1.
- Write responses: RO target or locked target -> SLVERR, no update. DECERR -> no update. Otherwise OKAY.
- Write semantics per byte lane, only where wstrb=1:
  - RW/WO/RC: replace the lane.
  - W1C: q &= ~wdata.
  - W1P: pulse_q=wdata for exactly one cycle; reg_q stays 0.
- hw_set: sets bits every cycle in W1C/RC registers. When set and clear hit the same cycle, set wins per bit.
- Read: AR accepted at T; rvalid=1 and rdata/rresp valid at T+1. Data is held stable while rvalid&&!rready. arready returns to 1 the cycle after the R handshake.
- Read data by type: RO returns hw_rdata, sampled at the T+1 edge. WO and W1P return 0, OKAY. DECERR returns 0.
- RC: register clears on the R handshake edge. A write commit or hw_set in that same cycle wins over the clear.
- Read and write paths run concurrently. A same-cycle write commit and read sample of one register returns the pre-write value.
- bvalid and rvalid never drop without their ready.

Decomposition:
- Package axil_regbank_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, reg-type enum, and a function that decodes address to {hit,idx}.
- One sub-module, axil_regbank_cell: a single register with its type parameter; handles strobe write, W1C, pulse, hw_set and read-clear. It is instantiated in a generate loop.

Test Plan:
- RW at idx 2 (BASE 0x100, DATA_W 32): write 0x1234_5678 to 0x108 with wstrb=0101, after reset value 0 -> read 0x0034_0078, OKAY; bvalid one cycle after the joint AW/W handshake.
- AW arrives 3 cycles before W, with bready held low for 4 cycles -> single commit, bvalid stable until bready, no second AW accepted meanwhile.
- W1C idx 3: hw_set=0xF, write 0x5 with hw_set bit0 still high the same cycle -> reads back 0xB.
- W1P idx 4: write 0x81 -> pulse_q[4]=0x81 for exactly one cycle; read returns 0.
- RC idx 5 holding 0xAA: read returns 0xAA, next read returns 0. Writing 0x11 in the handshake cycle leaves 0x11.
- Errors: write to RO -> SLVERR, value unchanged; write with lock=1 -> SLVERR; addr 0x0FC or 0x141 -> DECERR with rdata 0.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared definitions for the parametrised AXI4-Lite register bank:
// response codes, register types and the address decoder.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned IDX_W = 8;

    typedef enum logic [2:0] {
        RT_RW  = 3'd0,
        RT_RO  = 3'd1,
        RT_WO  = 3'd2,
        RT_W1C = 3'd3,
        RT_W1P = 3'd4,
        RT_RC  = 3'd5
    } reg_type_e;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Arithmetic decode: below-base, out-of-range and misaligned addresses all miss.
    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned num_regs,
                                         input int unsigned lane_lsb);
        logic [63:0] off;
        logic [63:0] word;
        dec_t        d;
        off   = addr - base;
        word  = off >> lane_lsb;
        d.idx = word[IDX_W-1:0];
        d.hit = (addr >= base) && (word < 64'(num_regs)) &&
                ((off & ((64'd1 << lane_lsb) - 64'd1)) == 64'd0);
        return d;
    endfunction

endpackage

// File: rtl/axil_regbank_cell.sv
// One register of the bank; its behaviour (RW/RO/WO/W1C/W1P/RC) is fixed by RTYPE.
module axil_regbank_cell
    import axil_regbank_pkg::*;
#(
    parameter int unsigned           DATA_W    = 32,
    parameter reg_type_e             RTYPE     = RT_RW,
    parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                rc_clr_i,
    input  logic [DATA_W-1:0]   hw_set_i,
    output logic [DATA_W-1:0]   q_o,
    output logic [DATA_W-1:0]   pulse_o
);
    localparam int unsigned       STRB_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] INIT   = (RTYPE == RT_RO || RTYPE == RT_W1P) ? '0 : RESET_VAL;

    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] pulse_q, pulse_d;
    logic [DATA_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            mask[b*8 +: 8] = {8{wstrb_i[b]}};
        end
    end

    // hw_set is applied last so a set always beats a same-cycle clear.
    always_comb begin
        q_d     = q_q;
        pulse_d = '0;
        case (RTYPE)
            RT_RW, RT_WO: begin
                if (wr_en_i) q_d = (q_q & ~mask) | (wdata_i & mask);
            end
            RT_W1C: begin
                if (wr_en_i) q_d = q_q & ~(wdata_i & mask);
                q_d = q_d | hw_set_i;
            end
            RT_RC: begin
                if (rc_clr_i) q_d = '0;
                if (wr_en_i) q_d = (q_q & ~mask) | (wdata_i & mask);
                q_d = q_d | hw_set_i;
            end
            RT_W1P: begin
                q_d = '0;
                if (wr_en_i) pulse_d = wdata_i & mask;
            end
            default: q_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= INIT;
            pulse_q <= '0;
        end else begin
            q_q     <= q_d;
            pulse_q <= pulse_d;
        end
    end

    assign q_o     = q_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/axil_regbank_param.sv
// Parametrised AXI4-Lite slave register bank with decode errors, write-lock,
// hardware status/set inputs and independent read and write paths.
module axil_regbank_param
    import axil_regbank_pkg::*;
#(
    parameter int unsigned                ADDR_W    = 12,
    parameter int unsigned                DATA_W    = 32,
    parameter int unsigned                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0]          BASE_ADDR = '0,
    parameter logic [NUM_REGS*3-1:0]      REG_TYPE  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            s_axil_awaddr,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [DATA_W-1:0]            s_axil_wdata,
    input  logic [DATA_W/8-1:0]          s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [ADDR_W-1:0]            s_axil_araddr,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [DATA_W-1:0]            s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_rdata,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    input  logic [NUM_REGS-1:0]          lock,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS*DATA_W-1:0]   pulse_q
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LANE_LSB = (DATA_W == 64) ? 3 : 2;

    logic                aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d, rd_hit_q, rd_hit_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;

    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_blocked;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data, rd_word;
    logic [STRB_W-1:0]   wr_strb;
    dec_t                wr_dec, rd_dec;
    logic [NUM_REGS-1:0] ro_vec, wr_sel, wr_en, rc_clr;
    logic [DATA_W-1:0]   rd_view [NUM_REGS];

    assign aw_hs  = s_axil_awvalid & ~aw_hold_q;
    assign w_hs   = s_axil_wvalid & ~w_hold_q;
    assign b_hs   = bvalid_q & s_axil_bready;
    assign ar_hs  = s_axil_arvalid & ~rvalid_q;
    assign r_hs   = rvalid_q & s_axil_rready;

    // A handshake in the current cycle counts as held, so AW+W at T commits at T.
    assign commit  = (aw_hold_q | aw_hs) & (w_hold_q | w_hs) & ~bvalid_q;
    assign wr_addr = aw_hold_q ? awaddr_q : s_axil_awaddr;
    assign wr_data = w_hold_q ? wdata_q : s_axil_wdata;
    assign wr_strb = w_hold_q ? wstrb_q : s_axil_wstrb;
    assign wr_dec  = addr_decode(64'(wr_addr), 64'(BASE_ADDR), NUM_REGS, LANE_LSB);
    assign rd_dec  = addr_decode(64'(s_axil_araddr), 64'(BASE_ADDR), NUM_REGS, LANE_LSB);

    always_comb begin
        wr_sel  = '0;
        rc_clr  = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (wr_dec.idx == IDX_W'(i));
            rc_clr[i] = r_hs & rd_hit_q & (rd_idx_q == IDX_W'(i));
            if (rd_dec.idx == IDX_W'(i)) rd_word = rd_view[i];
        end
        wr_blocked = |(wr_sel & (ro_vec | lock));
        wr_en      = (commit && wr_dec.hit && !wr_blocked) ? wr_sel : '0;
    end

    always_comb begin
        aw_hold_d = b_hs ? 1'b0 : (aw_hold_q | aw_hs);
        w_hold_d  = b_hs ? 1'b0 : (w_hold_q | w_hs);
        awaddr_d  = aw_hs ? s_axil_awaddr : awaddr_q;
        wdata_d   = w_hs ? s_axil_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;
        bvalid_d  = commit ? 1'b1 : (b_hs ? 1'b0 : bvalid_q);
        bresp_d   = bresp_q;
        if (commit) bresp_d = !wr_dec.hit ? RESP_DECERR : (wr_blocked ? RESP_SLVERR : RESP_OKAY);
        rvalid_d  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_idx_d  = rd_idx_q;
        rd_hit_d  = rd_hit_q;
        if (ar_hs) begin
            rdata_d  = rd_dec.hit ? rd_word : '0;
            rresp_d  = rd_dec.hit ? RESP_OKAY : RESP_DECERR;
            rd_idx_d = rd_dec.idx;
            rd_hit_d = rd_dec.hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_hold_q <= 1'b0;
            w_hold_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_idx_q  <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            aw_hold_q <= aw_hold_d;
            w_hold_q  <= w_hold_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rd_idx_q  <= rd_idx_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam reg_type_e T = reg_type_e'(REG_TYPE[3*g +: 3]);
        assign ro_vec[g]  = (T == RT_RO);
        assign rd_view[g] = (T == RT_RO) ? hw_rdata[g*DATA_W +: DATA_W] :
                            (T == RT_WO || T == RT_W1P) ? '0 : reg_q[g*DATA_W +: DATA_W];

        axil_regbank_cell #(
            .DATA_W    (DATA_W),
            .RTYPE     (T),
            .RESET_VAL (RESET_VAL[g*DATA_W +: DATA_W])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en[g]),
            .wdata_i  (wr_data),
            .wstrb_i  (wr_strb),
            .rc_clr_i (rc_clr[g]),
            .hw_set_i (hw_set[g*DATA_W +: DATA_W]),
            .q_o      (reg_q[g*DATA_W +: DATA_W]),
            .pulse_o  (pulse_q[g*DATA_W +: DATA_W])
        );
    end

    assign s_axil_awready = ~aw_hold_q;
    assign s_axil_wready  = ~w_hold_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = ~rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule
